// File: rtl/seg7_scan_display_if.sv
// Board-facing bundle for the eight-digit display driver: load port in,
// active-low segment and digit-select pins out.
interface seg7_scan_display_if;
  logic        cs;
  logic [31:0] i_data;
  logic        blank_lz;
  logic [7:0]  display7_seg;
  logic [7:0]  display7_sel;

  modport master (
    output cs, i_data, blank_lz,
    input  display7_seg, display7_sel
  );

  modport slave (
    input  cs, i_data, blank_lz,
    output display7_seg, display7_sel
  );
endinterface

// File: rtl/seg7_scan_display.sv
// Multiplexed 8-digit hex display driver: latches a 32-bit word and scans one
// digit at a time, each lit for REFRESH_DIV cycles, with optional leading-zero blanking.
module seg7_scan_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic               clk_in,
  input  logic               reset,
  seg7_scan_display_if.slave bus
);

  localparam int PCNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(REFRESH_DIV - 1);

  logic [31:0]       dreg_reg, dreg_next;
  logic [PCNT_W-1:0] pcnt_reg, pcnt_next;
  logic [2:0]        idx_reg, idx_next;
  logic [7:0]        seg_reg, seg_next;
  logic [7:0]        sel_reg, sel_next;
  logic              tick;

  logic [3:0]        nibble [8];
  logic [7:0]        blank_vec;

  function automatic logic [7:0] hex_decode(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_nibble
      assign nibble[gi] = dreg_reg[4*gi +: 4];
    end
  endgenerate

  // Digit k is a leading zero when every nibble from k up to the top is zero;
  // digit 0 always shows so that a zero value still displays "0".
  assign blank_vec[0] = 1'b0;
  generate
    for (gi = 1; gi < 8; gi++) begin : g_blank
      assign blank_vec[gi] = bus.blank_lz & ~(|dreg_reg[31:4*gi]);
    end
  endgenerate

  always_comb begin
    tick      = (pcnt_reg == PCNT_LAST);
    pcnt_next = tick ? '0 : pcnt_reg + 1'b1;
    idx_next  = tick ? idx_reg + 3'd1 : idx_reg;
    dreg_next = bus.cs ? bus.i_data : dreg_reg;
    sel_next  = ~(8'd1 << idx_reg);
    seg_next  = blank_vec[idx_reg] ? 8'hFF : hex_decode(nibble[idx_reg]);
  end

  // Outputs are registered from the pre-edge idx/dreg, giving a fixed one-cycle
  // pipeline and a glitch-free single-low select.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      dreg_reg <= '0;
      pcnt_reg <= '0;
      idx_reg  <= '0;
      seg_reg  <= 8'hFF;
      sel_reg  <= 8'hFF;
    end else begin
      dreg_reg <= dreg_next;
      pcnt_reg <= pcnt_next;
      idx_reg  <= idx_next;
      seg_reg  <= seg_next;
      sel_reg  <= sel_next;
    end
  end

  assign bus.display7_seg = seg_reg;
  assign bus.display7_sel = sel_reg;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed self-checking bench for seg7_scan_display with REFRESH_DIV=4.
module tb_seg7_scan_display;

  logic clk_in = 1'b0;
  logic reset  = 1'b0;
  int   tests  = 0;
  int   failed = 0;

  seg7_scan_display_if bus();

  seg7_scan_display #(.REFRESH_DIV(4)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Hold reset 3 cycles with the load port armed, release, and return just after
  // the first post-reset edge (dreg now holds value, outputs show digit 0 of zero).
  task automatic reset_and_load(input logic [31:0] value, input logic blank);
    @(negedge clk_in);
    reset = 1'b0;
    bus.cs = 1'b1;
    bus.i_data = value;
    bus.blank_lz = blank;
    #1;
    chk("rst async sel", bus.display7_sel, 8'hFF);
    chk("rst async seg", bus.display7_seg, 8'hFF);
    repeat (3) begin
      @(negedge clk_in);
      chk("rst hold sel", bus.display7_sel, 8'hFF);
      chk("rst hold seg", bus.display7_seg, 8'hFF);
    end
    reset = 1'b1;
    @(negedge clk_in);
    chk("rel sel", bus.display7_sel, 8'hFE);
    chk("rel seg", bus.display7_seg, 8'hC0);
    bus.cs = 1'b0;
  endtask

  // exp holds the expected segment byte of digit k at bits [8k+:8].
  task automatic run_scan(input logic [31:0] value, input logic blank, input logic [63:0] exp);
    logic [7:0] esel;
    reset_and_load(value, blank);
    for (int k = 0; k < 8; k++) begin
      esel = ~(8'd1 << k);
      @(negedge clk_in);
      chk($sformatf("%08h b%0d d%0d sel", value, blank, k), bus.display7_sel, esel);
      chk($sformatf("%08h b%0d d%0d seg", value, blank, k), bus.display7_seg, exp[8*k +: 8]);
      @(negedge clk_in);
      @(negedge clk_in);
      chk($sformatf("%08h b%0d d%0d end sel", value, blank, k), bus.display7_sel, esel);
      chk($sformatf("%08h b%0d d%0d end seg", value, blank, k), bus.display7_seg, exp[8*k +: 8]);
      @(negedge clk_in);
    end
    chk($sformatf("%08h wrap sel", value), bus.display7_sel, 8'hFE);
    chk($sformatf("%08h wrap seg", value), bus.display7_seg, exp[7:0]);
  endtask

  initial begin
    bus.cs = 1'b0;
    bus.i_data = '0;
    bus.blank_lz = 1'b0;

    run_scan(32'h12345678, 1'b0, 64'hF9A4B099_9282F880);
    run_scan(32'hFEDCBA90, 1'b0, 64'h8E86A1C6_838890C0);
    run_scan(32'h000000A5, 1'b1, 64'hFFFFFFFF_FFFF8892);
    run_scan(32'h000000A5, 1'b0, 64'hC0C0C0C0_C0C08892);
    run_scan(32'h00000000, 1'b1, 64'hFFFFFFFF_FFFFFFC0);
    run_scan(32'h00100005, 1'b1, 64'hFFFFF9C0_C0C0C092);

    // Load semantics: cs held while data steps 1,2,3, then dropped with F on the bus.
    reset_and_load(32'h1, 1'b0);
    bus.cs = 1'b1;
    bus.i_data = 32'h2;
    @(negedge clk_in);
    chk("load step1 seg", bus.display7_seg, 8'hF9);
    bus.i_data = 32'h3;
    @(negedge clk_in);
    chk("load step2 seg", bus.display7_seg, 8'hA4);
    bus.cs = 1'b0;
    bus.i_data = 32'hF;
    @(negedge clk_in);
    chk("load step3 sel", bus.display7_sel, 8'hFE);
    chk("load step3 seg", bus.display7_seg, 8'hB0);
    @(negedge clk_in);
    chk("load d1 sel", bus.display7_sel, 8'hFD);
    chk("load d1 seg", bus.display7_seg, 8'hC0);
    repeat (28) @(negedge clk_in);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("load hold c%0d sel", c), bus.display7_sel, 8'hFE);
      chk($sformatf("load hold c%0d seg", c), bus.display7_seg, 8'hB0);
      @(negedge clk_in);
    end

    // Async reset mid-scan at idx=5, pcnt=2 (just after edge 22).
    reset_and_load(32'h12345678, 1'b0);
    repeat (21) @(negedge clk_in);
    chk("mid pre sel", bus.display7_sel, 8'hDF);
    chk("mid pre seg", bus.display7_seg, 8'hB0);
    reset = 1'b0;
    #1;
    chk("mid async sel", bus.display7_sel, 8'hFF);
    chk("mid async seg", bus.display7_seg, 8'hFF);
    @(negedge clk_in);
    chk("mid hold sel", bus.display7_sel, 8'hFF);
    chk("mid hold seg", bus.display7_seg, 8'hFF);
    reset = 1'b1;
    @(negedge clk_in);
    chk("mid rel sel", bus.display7_sel, 8'hFE);
    chk("mid rel seg", bus.display7_seg, 8'hC0);
    repeat (3) @(negedge clk_in);
    chk("mid full period sel", bus.display7_sel, 8'hFE);
    chk("mid full period seg", bus.display7_seg, 8'hC0);
    @(negedge clk_in);
    chk("mid next digit sel", bus.display7_sel, 8'hFD);
    chk("mid next digit seg", bus.display7_seg, 8'hC0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/seg7_scan_display.md
# seg7_scan_display

Multiplexed eight-digit seven-segment display driver for the single-cycle computer top level. It consumes a 32-bit observation word, normally the CPU's current PC or a data-memory value, and shows it as eight hexadecimal digits. One digit is driven at a time with a programmable refresh period. The block sits directly downstream of the computer top level on the board-facing side and drives the `display7_seg` and `display7_sel` pins.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles each digit stays lit. Legal range is 1..2^20. The bench uses 4.
- `clk_in`  input  1  system clock. All state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `cs`  input  1  load enable. While high, `i_data` is captured every rising edge.
- `i_data`  input  32  value to display.
- `blank_lz`  input  1  when high, leading-zero digits are blanked.
- `display7_seg`  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.
- `display7_sel`  output  8  digit enables, active-low. Bit k selects digit k; digit 0 is the rightmost digit and shows `i_data[3:0]`.

## Operation
- **Data register `dreg` (32 bits).**
  - Reset value is 0.
  - Loads `i_data` on each edge where `cs`=1.
  - Holds its value when `cs`=0.
- **Prescaler `pcnt`.**
  - Width is ceil(log2(REFRESH_DIV)), minimum 1 bit. Reset value is 0.
  - Increments every cycle.
  - When `pcnt`==REFRESH_DIV-1, it wraps to 0 and `tick`=1 for that cycle.
  - With REFRESH_DIV=1, `tick` is permanently 1.
- **Digit index `idx` (3 bits).**
  - Reset value is 0.
  - Increments on `tick` and wraps 7→0. Scan order is 0,1,…,7,0.
- **Output registers.** Each edge loads values computed from the pre-edge `idx` and `dreg`:
  - `display7_sel` ← ~(1<<idx).
  - `display7_seg` ← decode(nibble idx of `dreg`), or 8'hFF if the digit is blanked.
- **Decode (dp always off, bit7=1).**
  - 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8.
  - 8→80, 9→90, A→88, b→83, C→C6, d→A1, E→86, F→8E.
- **Blanking rule.** Digit k (k≥1) is blanked when `blank_lz`=1 and nibbles 7 down to k of `dreg` are all zero.
  - Digit 0 is never blanked, so the value 0 shows a single "0".
  - `display7_sel` still selects a blanked digit.
- **Reset outputs.** `display7_seg`=8'hFF and `display7_sel`=8'hFF (all dark), applied immediately on reset assertion without waiting for a clock.

## Timing
- **After reset release.** The first rising edge loads digit 0: `sel`=8'hFE and `seg`=decode(`dreg[3:0]`).
- **Digit scan.**
  - `idx` changes on the edge ending a `tick` cycle.
  - The outputs follow one edge later, a fixed 1-cycle pipeline.
  - Each digit is shown for exactly REFRESH_DIV cycles. A full frame is 8×REFRESH_DIV cycles.
- **Load latency.** `cs` sampled high at edge n loads `dreg`. The new value first reaches the outputs at edge n+1, if that digit is then selected.
- **`cs` and `tick` in the same cycle.** Both updates occur at the same edge. The output computed at that edge uses the old `dreg` and the old `idx`.
- **`blank_lz` change.** Takes effect at the next edge, with no frame synchronisation.
- **Reset mid-scan.**
  - On assertion, all state and outputs go to their reset values asynchronously.
  - Scanning restarts at digit 0 with a full REFRESH_DIV period.
- **Dark-digit rule.** `sel` never has more than one bit low, including during the transition cycle.

## Test plan
- **Reset.** Hold `reset`=0 for 3 cycles.
  - Required: `seg`=FF and `sel`=FF throughout.
  - After release, one edge later: `sel`=FE and `seg`=C0.
- **Scan of 0x12345678** (REFRESH_DIV=4, `cs` pulse, `blank_lz`=0).
  - Required `sel`/`seg` pairs, each held 4 cycles then wrapping back to FE:
    - FE/80, FD/F8, FB/82, F7/92.
    - EF/99, DF/B0, BF/A4, 7F/F9.
- **Letters, 0xFEDCBA90.**
  - Required `seg` for digits 0..7: C0, 90, 88, 83, C6, A1, 86, 8E.
- **Leading-zero blanking, 0x000000A5 with `blank_lz`=1.**
  - Required: digits 0,1 show 92,88; digits 2..7 show FF.
  - With `blank_lz`=0, digits 2..7 show C0.
  - For value 0 with `blank_lz`=1, only digit 0 shows C0.
- **Load semantics.** Hold `cs`=1 while `i_data` steps 0x1→0x2→0x3, then drop `cs` and drive 0xF.
  - Required: digit 0 shows B0 (value 3) and never shows 8E.
- **Async reset mid-scan.** Assert `reset` at `idx`=5, `pcnt`=2 between edges.
  - Required: outputs read FF before the next edge.
  - On release, the scan resumes at FE with `dreg`=0, so `seg`=C0.
